// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StWaitRsp,
    StHold,
    StDrop,
    StHalt
  } fetch_state_e;

  localparam logic [31:0] NopInstr       = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, and a stalled live entry holds.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i && !(stall_i && valid_q)) begin
      valid_d    = 1'b1;
      pc_d       = pc_i;
      pc_plus4_d = pc_inc(pc_i);
      instr_d    = instr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: PC, single-outstanding imem fetch FSM, hold buffer and IF/ID register.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a HALT state.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_stall_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  redirect_target;
  logic         id_busy;
  logic         load;
  logic [31:0]  load_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  logic redirect_bad;

  assign redirect_target    = redirect_pc_i;
  assign redirect_bad       = redirect_pc_i[1:0] != 2'b00;
  assign fetch_misaligned_o = misaligned_q;
`else
  logic unused_redirect_lsb;

  assign redirect_target     = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
`endif

  // A live IF/ID entry that ID refuses has nowhere to go.
  assign id_busy          = id_stall_i & if_id_valid_o;
  assign imem_req_valid_o = !reset_i && (state_q == StFetch) && !redirect_valid_i && !id_busy;
  assign imem_addr_o      = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    hold_instr_d  = hold_instr_q;
    load          = 1'b0;
    load_instr    = imem_rsp_data_i;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_d  = misaligned_q;
`endif
    if (redirect_valid_i) begin
      pc_d         = redirect_target;
      hold_instr_d = '0;
      unique case (state_q)
        // An outstanding response must still be swallowed unless it lands now.
        StWaitRsp, StDrop: state_d = imem_rsp_valid_i ? StFetch : StDrop;
        default:           state_d = StFetch;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_d = redirect_bad;
      if (redirect_bad) state_d = StHalt;
`endif
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_req_valid_o && imem_req_ready_i) begin
            inflight_pc_d = pc_q;
            state_d       = StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (imem_rsp_valid_i) begin
            if (!id_busy) begin
              load    = 1'b1;
              pc_d    = pc_inc(inflight_pc_q);
              state_d = StFetch;
            end else begin
              hold_instr_d = imem_rsp_data_i;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (!id_stall_i) begin
            load       = 1'b1;
            load_instr = hold_instr_q;
            pc_d       = pc_inc(inflight_pc_q);
            state_d    = StFetch;
          end
        end
        StDrop: begin
          if (imem_rsp_valid_i) state_d = StFetch;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      hold_instr_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_instr_q  <= hold_instr_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) misaligned_q <= 1'b0;
    else         misaligned_q <= misaligned_d;
  end
`endif

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (redirect_valid_i),
    .load_i     (load),
    .stall_i    (id_stall_i),
    .pc_i       (inflight_pc_q),
    .instr_i    (load_instr),
    .valid_o    (if_id_valid_o),
    .pc_o       (if_id_pc_o),
    .pc_plus4_o (if_id_pc_plus4_o),
    .instr_o    (if_id_instr_o)
  );

endmodule
